// File: rtl/adc_fill_packer.sv
// Fill packer: header word, num_fill_bursts packed sample words, then XOR checksum word (out_last).
// Latency: start -> header 1 cycle; accepted input -> packed word on the next cycle.
// Backpressure: single output register; in_ready only in DATA while that register is free.
module adc_fill_packer #(
  parameter int ADC_BITS         = 12,
  parameter int SAMPLES_PER_WORD = 8,
  parameter int OVR_MODE         = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [23:0]                  fill_num,
  input  logic [22:0]                  burst_start_adr,
  input  logic [23:0]                  num_fill_bursts,
  input  logic [15:0]                  channel_tag,
  input  logic [1:0]                   fill_type,
  input  logic [8*(ADC_BITS+1)-1:0]    in_dat,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [127:0]                 out_dat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         ovr_seen
);

  localparam int LW = ADC_BITS + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HEADER   = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_CHECKSUM = 2'd3;

  generate
    if (SAMPLES_PER_WORD != 8) begin : g_spw_chk
      $error("adc_fill_packer: SAMPLES_PER_WORD must be 8");
    end
    if (ADC_BITS < 8 || ADC_BITS > 14) begin : g_bits_chk
      $error("adc_fill_packer: ADC_BITS must be in 8..14");
    end
  endgenerate

  logic [1:0]   state;
  logic [23:0]  word_cnt;
  logic [127:0] checksum;
  logic         csum_loaded;
  logic         out_free;
  logic         accept;
  logic [127:0] header;
  logic [127:0] pack_dat;
  logic         pack_ovr;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == S_DATA) && out_free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // Header word is built straight from the start-cycle fields
  assign header = {2'b01, 12'd0, fill_type, channel_tag, 8'd0, num_fill_bursts,
                   6'd0, burst_start_adr, 3'b000, 8'd0, fill_num};

  // Pack eight lanes into 16-bit slots, placing the over-range bit per OVR_MODE
  always_comb begin
    logic [LW-1:0] lane;
    lane     = '0;
    pack_dat = '0;
    pack_ovr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lane     = in_dat[LW*i +: LW];
      pack_ovr = pack_ovr | lane[0];
      if (OVR_MODE == 0)
        pack_dat[16*i +: 16] = {{(16-ADC_BITS){lane[ADC_BITS]}}, lane[ADC_BITS:1]};
      else
        pack_dat[16*i +: 16] = {{(15-ADC_BITS){lane[ADC_BITS]}}, lane[ADC_BITS:1], lane[0]};
    end
  end

  // Fill sequencer and output register; a consumed word empties the register unless reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      checksum    <= '0;
      csum_loaded <= 1'b0;
      out_dat     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      ovr_seen    <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            out_dat     <= header;
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            checksum    <= header;
            word_cnt    <= num_fill_bursts;
            ovr_seen    <= 1'b0;
            csum_loaded <= 1'b0;
            state       <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (out_free) begin
            if (word_cnt != 24'd0) begin
              state <= S_DATA;
            end else begin
              // Empty fill: the checksum is the header itself
              out_dat     <= checksum;
              out_valid   <= 1'b1;
              out_last    <= 1'b1;
              csum_loaded <= 1'b1;
              state       <= S_CHECKSUM;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            out_dat   <= pack_dat;
            out_valid <= 1'b1;
            checksum  <= checksum ^ pack_dat;
            ovr_seen  <= ovr_seen | pack_ovr;
            word_cnt  <= word_cnt - 24'd1;
            if (word_cnt == 24'd1) begin
              csum_loaded <= 1'b0;
              state       <= S_CHECKSUM;
            end
          end
        end
        S_CHECKSUM: begin
          if (!csum_loaded) begin
            // Load as soon as the last data word leaves the register
            if (out_free) begin
              out_dat     <= checksum;
              out_valid   <= 1'b1;
              out_last    <= 1'b1;
              csum_loaded <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_fill_packer.sv
// Scoreboard bench for adc_fill_packer: OVR_MODE 0 and 1 instances share all stimulus.
// Expected words come from an arithmetic model of each fill; a monitor pops them on handshakes.
// Backpressure is randomized on out_ready; stalled words are checked for stability.
module tb_adc_fill_packer;

  localparam int AB = 12;
  localparam int LW = AB + 1;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [23:0]      fill_num;
  logic [22:0]      burst_start_adr;
  logic [23:0]      num_fill_bursts;
  logic [15:0]      channel_tag;
  logic [1:0]       fill_type;
  logic [8*LW-1:0]  in_dat;
  logic             in_valid;
  logic             out_ready;
  logic             in_ready0, in_ready1;
  logic [127:0]     out_dat0, out_dat1;
  logic             out_valid0, out_valid1;
  logic             out_last0, out_last1;
  logic             busy0, busy1;
  logic             ovr_seen0, ovr_seen1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rmode  = 1'b0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;

  adc_fill_packer #(.ADC_BITS(AB), .SAMPLES_PER_WORD(8), .OVR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .fill_num(fill_num),
    .burst_start_adr(burst_start_adr), .num_fill_bursts(num_fill_bursts),
    .channel_tag(channel_tag), .fill_type(fill_type), .in_dat(in_dat),
    .in_valid(in_valid), .in_ready(in_ready0), .out_dat(out_dat0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .busy(busy0), .ovr_seen(ovr_seen0));

  adc_fill_packer #(.ADC_BITS(AB), .SAMPLES_PER_WORD(8), .OVR_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .fill_num(fill_num),
    .burst_start_adr(burst_start_adr), .num_fill_bursts(num_fill_bursts),
    .channel_tag(channel_tag), .fill_type(fill_type), .in_dat(in_dat),
    .in_valid(in_valid), .in_ready(in_ready1), .out_dat(out_dat1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .busy(busy1), .ovr_seen(ovr_seen1));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: always high, or random when rmode is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on every output handshake, check stability while stalled
  bit           prev_stall = 1'b0;
  logic [127:0] prev_dat   = '0;
  logic         prev_last  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 128'(out_valid0), 128'd1);
        chk("stall_dat", out_dat0, prev_dat);
        chk("stall_last", 128'(out_last0), 128'(prev_last));
      end
      if (out_valid0 && out_ready) begin
        n_chk++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word0: got %h expected no word at %0t", out_dat0, $time);
        end else begin
          n_chk--;
          e = q0.pop_front();
          chk("dat_mode0", out_dat0, e.d);
          chk("last_mode0", 128'(out_last0), 128'(e.last));
        end
      end
      if (out_valid1 && out_ready) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word1: got %h expected no word at %0t", out_dat1, $time);
        end else begin
          n_chk--;
          e = q1.pop_front();
          chk("dat_mode1", out_dat1, e.d);
          chk("last_mode1", 128'(out_last1), 128'(e.last));
        end
      end
      prev_stall = out_valid0 && !out_ready;
      prev_dat   = out_dat0;
      prev_last  = out_last0;
    end
  end

  // One complete fill: model pushes expected words, then drive start and samples
  // pat 0 = random, 1 = all samples 0xFFF no over-range, 2 = lane 3 = 0x800 with over-range
  task automatic run_fill(input int nb, input int pat, input bit hold, input logic [23:0] fnum);
    logic [22:0]     adr;
    logic [15:0]     tag;
    logic [1:0]      ft;
    logic [127:0]    hdr, c0, c1, w0, w1;
    logic [8*LW-1:0] vec;
    logic [8*LW-1:0] words[$];
    logic [AB-1:0]   samp;
    logic            ov;
    int              s, idx, cyc;
    bit              ovr_any, done;
    adr = 23'($urandom);
    tag = 16'($urandom);
    ft  = 2'($urandom);
    hdr = 128'(fnum) | (128'(adr) << 35) | (128'(nb) << 64) | (128'(tag) << 96)
        | (128'(ft) << 112) | (128'd1 << 126);
    q0.push_back('{hdr, 1'b0});
    q1.push_back('{hdr, 1'b0});
    c0 = hdr;
    c1 = hdr;
    ovr_any = 1'b0;
    for (int w = 0; w < nb; w++) begin
      for (int l = 0; l < 8; l++) begin
        case (pat)
          1: begin samp = '1; ov = 1'b0; end
          2: begin
            if (l == 3) begin samp = AB'(1 << (AB - 1)); ov = 1'b1; end
            else begin samp = AB'($urandom_range(0, (1 << AB) - 1)); ov = 1'b0; end
          end
          default: begin
            samp = AB'($urandom_range(0, (1 << AB) - 1));
            ov   = ($urandom_range(0, 7) == 0);
          end
        endcase
        vec[LW*l +: LW] = {samp, ov};
        s = int'(samp);
        if (s >= (1 << (AB - 1))) s = s - (1 << AB);
        w0[16*l +: 16] = 16'(s);
        w1[16*l +: 16] = 16'(2 * s + int'(ov));
        ovr_any = ovr_any | ov;
      end
      words.push_back(vec);
      q0.push_back('{w0, 1'b0});
      q1.push_back('{w1, 1'b0});
      c0 = c0 ^ w0;
      c1 = c1 ^ w1;
    end
    q0.push_back('{c0, 1'b1});
    q1.push_back('{c1, 1'b1});

    @(posedge clk);
    #1;
    start = 1'b1;
    fill_num = fnum;
    burst_start_adr = adr;
    num_fill_bursts = 24'(nb);
    channel_tag = tag;
    fill_type = ft;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    // Scramble fields after start: the header must already be captured
    fill_num = 24'($urandom);
    num_fill_bursts = 24'($urandom);
    idx = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < (nb + 4) * 30) begin
      in_valid = (idx < nb) && ($urandom_range(0, 3) != 0);
      if (idx < nb) in_dat = words[idx];
      @(negedge clk);
      if (in_valid && in_ready0) idx++;
      if (out_valid0 && out_ready && out_last0) done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("fill_done", 128'(done), 128'd1);
    chk("busy_after_fill", 128'(busy0), 128'd0);
    chk("ovr_seen_mode0", 128'(ovr_seen0), 128'(ovr_any));
    chk("ovr_seen_mode1", 128'(ovr_seen1), 128'(ovr_any));
    chk("queue_drained", 128'(q0.size() + q1.size()), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8*LW-1:0] v;
    rst_n = 1'b0;
    start = 1'b0;
    fill_num = '0;
    burst_start_adr = '0;
    num_fill_bursts = '0;
    channel_tag = '0;
    fill_type = '0;
    in_dat = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid0), 128'd0);
    chk("rst_out_dat", out_dat0, 128'd0);
    chk("rst_out_last", 128'(out_last0), 128'd0);
    chk("rst_in_ready", 128'(in_ready0), 128'd0);
    chk("rst_busy", 128'(busy0), 128'd0);
    chk("rst_ovr_seen", 128'(ovr_seen0), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_fill(0, 0, 1'b0, 24'h000123);
    run_fill(2, 1, 1'b0, 24'($urandom));
    run_fill(2, 2, 1'b0, 24'($urandom));
    rmode = 1'b1;
    run_fill(16, 0, 1'b0, 24'($urandom));
    rmode = 1'b0;
    run_fill(3, 0, 1'b1, 24'($urandom));
    run_fill(4, 0, 1'b0, 24'($urandom));

    // Reset in the middle of DATA after over-range samples were accepted
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    start = 1'b1;
    num_fill_bursts = 24'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int l = 0; l < 8; l++) v[LW*l +: LW] = {AB'($urandom_range(0, (1 << AB) - 1)), 1'b1};
    in_dat = v;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy0), 128'd1);
    chk("mid_ovr_seen", 128'(ovr_seen0), 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid0), 128'd0);
    chk("arst_out_dat", out_dat0, 128'd0);
    chk("arst_out_last", 128'(out_last0), 128'd0);
    chk("arst_in_ready", 128'(in_ready0), 128'd0);
    chk("arst_busy", 128'(busy0), 128'd0);
    chk("arst_ovr_seen", 128'(ovr_seen0), 128'd0);
    chk("arst_out_valid1", 128'(out_valid1), 128'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_fill(2, 0, 1'b0, 24'($urandom));

    for (int k = 0; k < 6; k++) begin
      rmode = 1'($urandom_range(0, 1));
      run_fill($urandom_range(0, 6), 0, 1'($urandom_range(0, 1)), 24'($urandom));
    end
    rmode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
